// File: rtl/fma16_arbiter.sv
// rtl/fma16_arbiter.sv - round-robin arbiter sequencing NREQ requesters onto one fma16 datapath
// Operands are registered before the fma16 and the result is registered after it.

module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [1:0]  roundmode,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  logic [15:0] ya, za;
  logic        x_nan, y_nan, z_nan, any_snan;
  logic        x_inf, y_inf, z_inf, x_zero, y_zero;
  logic        p_inf, inf_times_zero, inf_cancel, invalid;
  logic        ps, sz, rs, zero_sign;
  logic [4:0]  xeff, yeff, zeff;
  logic [21:0] pm;
  logic [81:0] pval, zval, mag, low_mask;
  logic [6:0]  lead, k, ebase;
  logic [10:0] kept;
  logic        round_bit, sticky, inc, to_inf, tiny;
  logic [16:0] res_w;

  assign ya = mul ? y : 16'h3C00;
  assign za = add ? z : 16'h0000;

  assign x_nan  = (&x[14:10]) & (|x[9:0]);
  assign y_nan  = (&ya[14:10]) & (|ya[9:0]);
  assign z_nan  = (&za[14:10]) & (|za[9:0]);
  assign any_snan = (x_nan & ~x[9]) | (y_nan & ~ya[9]) | (z_nan & ~za[9]);
  assign x_inf  = (&x[14:10]) & ~(|x[9:0]);
  assign y_inf  = (&ya[14:10]) & ~(|ya[9:0]);
  assign z_inf  = (&za[14:10]) & ~(|za[9:0]);
  assign x_zero = ~(|x[14:0]);
  assign y_zero = ~(|ya[14:0]);

  assign ps = x[15] ^ ya[15] ^ negp;
  assign sz = za[15] ^ negz;
  assign p_inf = x_inf | y_inf;
  assign inf_times_zero = (x_inf & y_zero) | (y_inf & x_zero);
  assign inf_cancel = p_inf & z_inf & (ps != sz);
  assign invalid = any_snan | inf_times_zero | inf_cancel;

  assign xeff = (|x[14:10]) ? x[14:10] : 5'd1;
  assign yeff = (|ya[14:10]) ? ya[14:10] : 5'd1;
  assign zeff = (|za[14:10]) ? za[14:10] : 5'd1;

  // Both terms land exactly on one fixed-point grid with LSB 2^-48, so the sum is exact.
  assign pm   = {11'd0, |x[14:10], x[9:0]} * {11'd0, |ya[14:10], ya[9:0]};
  assign pval = {60'd0, pm} << ({2'd0, xeff} + {2'd0, yeff} - 7'd2);
  assign zval = {71'd0, |za[14:10], za[9:0]} << ({2'd0, zeff} + 7'd23);

  always_comb begin
    if (ps == sz) begin
      mag = pval + zval;
      rs  = ps;
    end else if (pval >= zval) begin
      mag = pval - zval;
      rs  = ps;
    end else begin
      mag = zval - pval;
      rs  = sz;
    end
  end

  always_comb begin
    lead = 7'd0;
    for (int i = 0; i < 82; i++) begin
      if (mag[i]) lead = 7'(i);
    end
  end

  // Subnormal results keep bit 24 (2^-24) as LSB; adding kept onto the exponent base lets a
  // mantissa carry roll naturally into the exponent field.
  always_comb begin
    tiny      = lead < 7'd34;
    k         = tiny ? 7'd24 : lead - 7'd10;
    ebase     = tiny ? 7'd0 : lead - 7'd34;
    kept      = 11'(mag >> k);
    round_bit = mag[k - 7'd1];
    low_mask  = (82'd1 << (k - 7'd1)) - 82'd1;
    sticky    = |(mag & low_mask);
    case (roundmode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = round_bit & (sticky | kept[0]);
      2'b10:   inc = (round_bit | sticky) & rs;
      default: inc = (round_bit | sticky) & ~rs;
    endcase
    res_w     = {ebase, 10'd0} + {6'd0, kept} + {16'd0, inc};
    to_inf    = (roundmode == 2'b01) | ((roundmode == 2'b10) & rs) | ((roundmode == 2'b11) & ~rs);
    zero_sign = (ps == sz) ? ps : (roundmode == 2'b10);
  end

  always_comb begin
    result = {rs, res_w[14:0]};
    flags  = {2'b00, tiny & (round_bit | sticky), round_bit | sticky};
    if (x_nan | y_nan | z_nan | invalid) begin
      result = 16'h7E00;
      flags  = {invalid, 3'b000};
    end else if (p_inf) begin
      result = {ps, 15'h7C00};
      flags  = 4'b0000;
    end else if (z_inf) begin
      result = {sz, 15'h7C00};
      flags  = 4'b0000;
    end else if (mag == 82'd0) begin
      result = {zero_sign, 15'h0000};
      flags  = 4'b0000;
    end else if (res_w >= 17'h07C00) begin
      result = to_inf ? {rs, 15'h7C00} : {rs, 15'h7BFF};
      flags  = 4'b0101;
    end
  end
endmodule

module fma16_arbiter #(
  parameter int NREQ = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [6*NREQ-1:0]    req_ctrl,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [15:0]          resp_result,
  output logic [3:0]           resp_flags,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   owner_q, owner_d;
  logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [5:0]      ctrl_q, ctrl_d;
  logic [15:0]     result_q, result_d;
  logic [3:0]      flags_q, flags_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic            grant_valid;
  logic [GW-1:0]   grant_idx, cand;
  logic [15:0]     fma_result;
  logic [3:0]      fma_flags;

  // Search downward so the requester closest after last_grant is the final (winning) hit.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i]  = (state_q == IDLE) && grant_valid && (grant_idx == GW'(i));
      resp_valid[i] = (state_q == RESP) && (owner_q == GW'(i));
    end
  end

  assign busy        = (state_q != IDLE);
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign op_count    = op_count_q;

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    flags_d      = flags_q;
    op_count_d   = op_count_q;
    if (state_q == IDLE && grant_valid) begin
      owner_d = grant_idx;
      x_d     = req_x[16*grant_idx +: 16];
      y_d     = req_y[16*grant_idx +: 16];
      z_d     = req_z[16*grant_idx +: 16];
      ctrl_d  = req_ctrl[6*grant_idx +: 6];
    end
    if (state_q == EXEC) begin
      result_d = fma_result;
      flags_d  = fma_flags;
    end
    if (state_q == RESP && resp_ready[owner_q]) begin
      last_grant_d = owner_q;
      op_count_d   = op_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GW'(NREQ - 1);
      owner_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      op_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      op_count_q   <= op_count_d;
    end
  end

  fma16 u_fma16 (
    .x         (x_q),
    .y         (y_q),
    .z         (z_q),
    .roundmode (ctrl_q[5:4]),
    .mul       (ctrl_q[3]),
    .add       (ctrl_q[2]),
    .negp      (ctrl_q[1]),
    .negz      (ctrl_q[0]),
    .result    (fma_result),
    .flags     (fma_flags)
  );
endmodule

// File: doc/fma16_arbiter.md
Name: fma16_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational fma16 datapath among NREQ requesters.
- Each requester issues an operation (x, y, z, ctrl) on a valid/ready handshake and receives result and flags on a per-requester valid/ready response channel.
- The block registers operands before the datapath and registers the result after it.
- It sits between fma16 clients (e.g. vector/dot-product sequencers, test drivers) and the single fma16 instance it contains.

Parameters:
NREQ, 2, number of requesters (1..8); NREQ=1 degenerates to a registered wrapper
CNTW, 16, width of the completed-operation counter

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-low
req_valid  input  NREQ  request valid, one bit per requester
req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
req_x  input  16*NREQ  fp16 multiplicand; requester i at bits [16i+15:16i]
req_y  input  16*NREQ  fp16 multiplier, same packing
req_z  input  16*NREQ  fp16 addend, same packing
req_ctrl  input  6*NREQ  per requester {roundmode[1:0], mul, add, negp, negz}, packing [6i+5:6i]
resp_valid  output  NREQ  result valid for owning requester (one-hot or zero)
resp_ready  input  NREQ  requester consumes result
resp_result  output  16  fp16 result, shared bus, meaningful only with resp_valid
resp_flags  output  4  {invalid, overflow, underflow, inexact}, shared bus
busy  output  1  high whenever state != IDLE
op_count  output  CNTW  number of completed responses, wraps

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; last_grant=NREQ-1, so requester 0 has highest priority first.
  - req_ready=0, resp_valid=0, resp_result=0, resp_flags=0, busy=0, op_count=0.
  - Operand registers are cleared to 0.
  - Reset overrides everything, including mid-EXEC/RESP; an aborted operation produces no response.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i], searching last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits 0.
  - At posedge: latch x, y, z, ctrl of g and owner=g; go to EXEC.
  - No req_valid: stay in IDLE, req_ready=0.
- EXEC: fma16 is driven from the latched registers. At posedge, capture result/flags into resp_result/resp_flags and go to RESP. req_ready=0.
- RESP:
  - resp_valid[owner]=1; resp_result/resp_flags held stable.
  - When resp_ready[owner]=1 at posedge: go to IDLE, last_grant=owner, op_count+=1 (wraps all-ones -> 0), resp_valid drops the next cycle.
  - resp_ready from non-owners is ignored.
  - req_ready=0 throughout RESP.
- Timing:
  - Handshake at posedge t -> resp_valid high from cycle t+2.
  - Minimum 3 cycles per operation; no new grant until the response is consumed.
- Requester may drop req_valid before acceptance with no side effect. Operands are sampled only on the accept edge; later input changes do not affect the in-flight op.
- resp_valid is never asserted for more than one requester; req_ready is never asserted outside IDLE.
- Arithmetic is entirely the fma16 instance's: ctrl bits are passed unmodified, and no rounding or flag logic lives here.

Test Plan:
- Single op: requester 0, x=3C00, y=4000, z=3C00, ctrl=6'b01_1_1_0_0 accepted at cycle t -> resp_valid[0] at t+2, resp_result=4200, resp_flags=0000, op_count=1.
- Simultaneous: req_valid=2'b11 right after reset -> req0 granted first; req1 granted in the IDLE cycle after req0's response is consumed.
- Fairness: both requesters held valid for 6 ops -> grant order 0,1,0,1,0,1; op_count=6.
- Backpressure: resp_ready low 5 cycles in RESP -> resp_valid, resp_result and resp_flags stable; req_ready=0; busy=1; op_count unchanged until consumed.
- Negated product: requester 1, x=4000, y=4000, z=4200, mul=add=negp=1 -> resp_result=BC00 (-1.0) on resp_valid[1] only.
- Reset mid-EXEC: reset=0 for one edge while in EXEC -> next cycle all outputs 0, state IDLE, no resp_valid ever issued for the aborted op; op_count=0.
